// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enabled simple dual-port RAM family.
package ram_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } ram_state_e;

  localparam int RD_LAT_1 = 32'sd1;
  localparam int RD_LAT_2 = 32'sd2;
  localparam int RDW_OLD  = 32'sd0;
  localparam int RDW_NEW  = 32'sd1;

  function automatic int nbytes(input int dwidth);
    return dwidth / 32'sd8;
  endfunction

  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
    logic [7:0] res;
    if (be) begin
      res = new_b;
    end else begin
      res = old_b;
    end
    return res;
  endfunction

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-result pipeline: 1 or 2 register stages carrying {payload, valid}.
// Payload bits selected by CLR_MASK drop to 0 when no result is carried; the rest hold.
module ram_rd_pipe
  import ram_pkg::*;
#(
  parameter int             RD_LATENCY = RD_LAT_1,
  parameter int             W          = 32,
  parameter logic [W-1:0]   CLR_MASK   = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         s1_valid_r;
  logic [W-1:0] s1_data_r;

  // First stage: also serves as the array read register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= '0;
    end else begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_data_r <= in_data;
      end else begin
        s1_data_r <= s1_data_r & ~CLR_MASK;
      end
    end
  end

  generate
    if (RD_LATENCY == RD_LAT_2) begin : g_lat2
      logic         s2_valid_r;
      logic [W-1:0] s2_data_r;

      // Optional output register stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid_r <= 1'b0;
          s2_data_r  <= '0;
        end else begin
          s2_valid_r <= s1_valid_r;
          if (s1_valid_r) begin
            s2_data_r <= s1_data_r;
          end else begin
            s2_data_r <= s2_data_r & ~CLR_MASK;
          end
        end
      end

      assign out_valid = s2_valid_r;
      assign out_data  = s2_data_r;
    end else begin : g_lat1
      assign out_valid = s1_valid_r;
      assign out_data  = s1_data_r;
    end
  endgenerate

endmodule

// File: rtl/ram_sdp_be.sv
// Simple dual-port RAM with byte enables, post-reset clear sweep and read-valid strobe.
// Optional per-byte parity storage and checking with macro RAM_SDP_BE_PARITY_EN.
module ram_sdp_be
  import ram_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 8,
  parameter int DEPTH      = 1 << AWIDTH,
  parameter int RD_LATENCY = RD_LAT_1,
  parameter int RDW_MODE   = RDW_OLD
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  input  logic                  wr_en,
  input  logic [AWIDTH-1:0]     wr_addr,
  input  logic [DWIDTH-1:0]     wr_data,
  input  logic [DWIDTH/8-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [AWIDTH-1:0]     rd_addr,
  output logic [DWIDTH-1:0]     rd_data,
`ifdef RAM_SDP_BE_PARITY_EN
  input  logic                  perr_inject,
  output logic [DWIDTH/8-1:0]   rd_perr,
`endif
  output logic                  rd_valid
);

  localparam int                NB        = nbytes(DWIDTH);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);
  localparam logic [AWIDTH:0]   DEPTH_W   = (AWIDTH + 1)'(DEPTH);
  localparam logic              WR_FIRST  = (RDW_MODE == RDW_NEW);
`ifdef RAM_SDP_BE_PARITY_EN
  localparam int                PW        = DWIDTH + NB;
  localparam logic [PW-1:0]     CLR_MASK  = {{NB{1'b1}}, {DWIDTH{1'b0}}};
`else
  localparam int                PW        = DWIDTH;
  localparam logic [PW-1:0]     CLR_MASK  = '0;
`endif

  ram_state_e        state_r, state_nx_s;
  logic [AWIDTH-1:0] clr_cnt_r, clr_cnt_nx_s;
  logic              init_busy_r;

  logic [DWIDTH-1:0] mem [DEPTH];
`ifdef RAM_SDP_BE_PARITY_EN
  logic [NB-1:0]     par_mem [DEPTH];
  logic              par_b_s;
`endif

  logic              wr_go_s, rd_go_s, merge_s;
  logic [PW-1:0]     rd_pay_s, rd_pay_q_s;

  assign wr_go_s = wr_en && !init_busy_r && ({1'b0, wr_addr} < DEPTH_W);
  assign rd_go_s = rd_en && !init_busy_r;
  assign merge_s = WR_FIRST && wr_go_s && (wr_addr == rd_addr);

  // Clear-sweep sequencing: INIT walks every address once, RUN is terminal.
  always_comb begin
    state_nx_s   = state_r;
    clr_cnt_nx_s = clr_cnt_r;
    case (state_r)
      INIT: begin
        if (clr_cnt_r == LAST_ADDR) begin
          state_nx_s = RUN;
        end else begin
          clr_cnt_nx_s = clr_cnt_r + AWIDTH'(1);
        end
      end
      RUN: begin
        state_nx_s = RUN;
      end
      default: begin
        state_nx_s   = INIT;
        clr_cnt_nx_s = '0;
      end
    endcase
  end

  // State, sweep counter and busy flag; busy drops on the edge that writes the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= INIT;
      clr_cnt_r   <= '0;
      init_busy_r <= 1'b1;
    end else begin
      state_r     <= state_nx_s;
      clr_cnt_r   <= clr_cnt_nx_s;
      init_busy_r <= (state_nx_s == INIT);
    end
  end

  // Array write port: the sweep owns the array while INIT, then byte-enabled writes.
  always_ff @(posedge clk) begin
    if (state_r == INIT) begin
      mem[clr_cnt_r] <= '0;
`ifdef RAM_SDP_BE_PARITY_EN
      par_mem[clr_cnt_r] <= '0;
`endif
    end else if (wr_go_s) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
`ifdef RAM_SDP_BE_PARITY_EN
          par_mem[wr_addr][i] <= byte_parity(wr_data[8*i +: 8]) ^ perr_inject;
`endif
        end
      end
    end
  end

  // Read word selection, including write-first merge and out-of-range zero result.
  always_comb begin
    rd_pay_s = '0;
`ifdef RAM_SDP_BE_PARITY_EN
    par_b_s  = 1'b0;
`endif
    if ({1'b0, rd_addr} < DEPTH_W) begin
      for (int i = 0; i < NB; i++) begin
        if (merge_s) begin
          rd_pay_s[8*i +: 8] = byte_merge(mem[rd_addr][8*i +: 8], wr_data[8*i +: 8], wr_be[i]);
        end else begin
          rd_pay_s[8*i +: 8] = mem[rd_addr][8*i +: 8];
        end
`ifdef RAM_SDP_BE_PARITY_EN
        if (merge_s && wr_be[i]) begin
          par_b_s = byte_parity(wr_data[8*i +: 8]) ^ perr_inject;
        end else begin
          par_b_s = par_mem[rd_addr][i];
        end
        rd_pay_s[DWIDTH+i] = byte_parity(rd_pay_s[8*i +: 8]) ^ par_b_s;
`endif
      end
    end else begin
      rd_pay_s = '0;
    end
  end

  ram_rd_pipe #(
    .RD_LATENCY (RD_LATENCY),
    .W          (PW),
    .CLR_MASK   (CLR_MASK)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_go_s),
    .in_data   (rd_pay_s),
    .out_valid (rd_valid),
    .out_data  (rd_pay_q_s)
  );

  assign rd_data   = rd_pay_q_s[DWIDTH-1:0];
  assign init_busy = init_busy_r;
`ifdef RAM_SDP_BE_PARITY_EN
  assign rd_perr   = rd_pay_q_s[PW-1:DWIDTH];
`endif

endmodule
